// File: rtl/wb_retire_queue_if.sv
// MEM-to-WB completion channel: one completed instruction per push (valid & ready).
// Handshake: a transfer happens on a rising edge where in_valid and in_ready are both high; MEM holds its payload stable while in_valid is high and in_ready is low.
interface wb_retire_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [PC_W-1:0]       in_pc;
  logic [DATA_W/8-1:0]   in_rf_wen;
  logic [ADDR_W-1:0]     in_rf_waddr;
  logic [DATA_W-1:0]     in_rf_wdata;
  logic                  in_hi_we;
  logic                  in_lo_we;
  logic [DATA_W-1:0]     in_hi;
  logic [DATA_W-1:0]     in_lo;

  modport master (
    output in_valid, in_pc, in_rf_wen, in_rf_waddr, in_rf_wdata,
    output in_hi_we, in_lo_we, in_hi, in_lo,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_rf_wen, in_rf_waddr, in_rf_wdata,
    input  in_hi_we, in_lo_we, in_hi, in_lo,
    output in_ready
  );
endinterface

// File: rtl/wb_retire_queue.sv
// In-order write-back retire queue: buffers completed instructions, retires one per
// cycle to RF and HI/LO, and offers a byte-merged forwarding lookup over buffered writes.
module wb_retire_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  wb_retire_queue_if.slave        s_in,
  input  logic                    retire_stall,
  output logic [DATA_W/8-1:0]     rf_wen,
  output logic [ADDR_W-1:0]       rf_waddr,
  output logic [DATA_W-1:0]       rf_wdata,
  output logic [2*DATA_W+1:0]     hilo_bus,
  output logic [PC_W-1:0]         debug_wb_pc,
  output logic [DATA_W/8-1:0]     debug_wb_rf_wen,
  output logic [ADDR_W-1:0]       debug_wb_rf_wnum,
  output logic [DATA_W-1:0]       debug_wb_rf_wdata,
  input  logic [ADDR_W-1:0]       fwd_raddr,
  output logic [DATA_W/8-1:0]     fwd_bmask,
  output logic [DATA_W-1:0]       fwd_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NB    = DATA_W / 8;

  logic [PC_W-1:0]   r_pc    [DEPTH];
  logic [NB-1:0]     r_wen   [DEPTH];
  logic [ADDR_W-1:0] r_waddr [DEPTH];
  logic [DATA_W-1:0] r_wdata [DEPTH];
  logic              r_hi_we [DEPTH];
  logic              r_lo_we [DEPTH];
  logic [DATA_W-1:0] r_hi    [DEPTH];
  logic [DATA_W-1:0] r_lo    [DEPTH];

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_commit;
  logic              w_push;
  logic [PTR_W-1:0]  w_fwd_idx;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_commit = ~w_empty & ~retire_stall;
  // A full queue can still accept when the head leaves in the same cycle.
  assign s_in.in_ready = ~w_full | w_commit;
  assign w_push   = s_in.in_valid & s_in.in_ready;

  assign count = r_count;
  assign full  = w_full;
  assign empty = w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)   r_tail <= r_tail + 1'b1;
      if (w_commit) r_head <= r_head + 1'b1;
      case ({w_push, w_commit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_tail]    <= s_in.in_pc;
      r_wen[r_tail]   <= s_in.in_rf_wen;
      r_waddr[r_tail] <= s_in.in_rf_waddr;
      r_wdata[r_tail] <= s_in.in_rf_wdata;
      r_hi_we[r_tail] <= s_in.in_hi_we;
      r_lo_we[r_tail] <= s_in.in_lo_we;
      r_hi[r_tail]    <= s_in.in_hi;
      r_lo[r_tail]    <= s_in.in_lo;
    end
  end

  always_comb begin
    rf_wen            = '0;
    rf_waddr          = '0;
    rf_wdata          = '0;
    hilo_bus          = '0;
    debug_wb_pc       = '0;
    debug_wb_rf_wen   = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    if (w_commit) begin
      rf_wen            = (r_waddr[r_head] != '0) ? r_wen[r_head] : '0;
      rf_waddr          = r_waddr[r_head];
      rf_wdata          = r_wdata[r_head];
      hilo_bus          = {r_hi_we[r_head], r_lo_we[r_head], r_hi[r_head], r_lo[r_head]};
      debug_wb_pc       = r_pc[r_head];
      debug_wb_rf_wen   = rf_wen;
      debug_wb_rf_wnum  = r_waddr[r_head];
      debug_wb_rf_wdata = r_wdata[r_head];
    end
  end

  // Walk oldest to newest so a younger matching byte overrides an older one.
  always_comb begin
    fwd_bmask = '0;
    fwd_data  = '0;
    w_fwd_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_fwd_idx = r_head + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && (fwd_raddr != '0) && (r_waddr[w_fwd_idx] == fwd_raddr)) begin
        for (int b = 0; b < NB; b++) begin
          if (r_wen[w_fwd_idx][b]) begin
            fwd_bmask[b]       = 1'b1;
            fwd_data[8*b +: 8] = r_wdata[w_fwd_idx][8*b +: 8];
          end
        end
      end
    end
  end
endmodule
